// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream
// requesters. Round-robin arbitration at message granularity. An optional
// one-byte channel tag (TAG_BASE + grant) goes out before each granted message.
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          MAX_BURST    = 64,
    parameter int          IDLE_TIMEOUT = 1024,
    parameter int          TAG_EN       = 1,
    parameter logic [7:0]  TAG_BASE     = 8'h80,
    localparam int         GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    // Counter widths; a zero limit still needs one bit of storage.
    localparam int BW = (MAX_BURST    > 0) ? $clog2(MAX_BURST + 1)    : 1;
    localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TAG  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [BW-1:0] burst_cnt;
    logic [IW-1:0] idle_cnt;

    logic [GW-1:0] winner;
    logic [GW-1:0] cand;
    logic          win_found;

    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;
    logic          xfer_data;
    logic [BW-1:0] burst_next;
    logic [IW-1:0] idle_next;
    logic          burst_hit;
    logic          idle_hit;

    // Round-robin pick: first valid requester after last_grant, with wrap,
    // so the one just released ranks lowest.
    always_comb begin
        winner    = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                winner    = cand;
            end
        end
    end

    // Granted requester's signals and the saturating counter increments.
    always_comb begin
        sel_valid  = req_valid[grant];
        sel_last   = req_last[grant];
        sel_data   = req_data[8*int'(grant) +: 8];
        xfer_data  = (state == S_DATA) && sel_valid && tx_ready;
        burst_next = (burst_cnt == BW'(MAX_BURST))    ? burst_cnt : burst_cnt + 1'b1;
        idle_next  = (idle_cnt  == IW'(IDLE_TIMEOUT)) ? idle_cnt  : idle_cnt  + 1'b1;
        burst_hit  = (MAX_BURST    != 0) && (burst_next == BW'(MAX_BURST));
        idle_hit   = (IDLE_TIMEOUT != 0) && (idle_next  == IW'(IDLE_TIMEOUT));
    end

    // Output path: tag or granted byte; gated by reset so nothing leaves
    // in a reset cycle. Never looks at tx_ready for tx_valid/tx_data.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (!reset) begin
            if (state == S_TAG) begin
                tx_valid = 1'b1;
                tx_data  = TAG_BASE + 8'(grant);
            end else if (state == S_DATA) begin
                tx_valid = sel_valid;
                tx_data  = sel_data;
                req_ready[grant] = tx_ready;
            end
        end
    end

    // Grant FSM: arbitrate in IDLE, send tag, stream data until last byte,
    // burst limit or idle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            burst_cnt  <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant     <= winner;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= (TAG_EN != 0) ? S_TAG : S_DATA;
                    end
                end
                S_TAG: begin
                    if (tx_ready)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (xfer_data) begin
                        burst_cnt <= burst_next;
                        idle_cnt  <= '0;
                        if (sel_last || burst_hit) begin
                            state      <= S_IDLE;
                            last_grant <= grant;
                        end
                    end else if (!sel_valid) begin
                        idle_cnt <= idle_next;
                        if (idle_hit) begin
                            state      <= S_IDLE;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign grant_id = grant;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// traffic, checked each cycle against a behavioural model and against
// expected serial byte streams.
module tb_uart_tx_arbiter;

    localparam int         N  = 4;
    localparam int         MB = 4;
    localparam int         IT = 8;
    localparam int         TE = 1;
    localparam logic [7:0] TB = 8'h80;
    localparam int         GW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [GW-1:0]    grant_id;
    logic             busy;

    uart_tx_arbiter #(
        .NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT), .TAG_EN(TE), .TAG_BASE(TB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Requester message queues: {last, byte}
    logic [8:0] rq[N][$];
    logic [7:0] lg[$];
    int  vmode = 1;   // 1: valid whenever data queued, 0: random gaps
    int  rmode = 1;   // 1: tx_ready high, 0: low, 2: random
    bit  live  = 0;

    // Reference model: owner (-1 = nobody), tag pending, counters.
    int  m_own = -1, m_g = 0, m_last = N - 1, m_b = 0, m_i = 0;
    bit  m_tag = 0;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_data[i*8 +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
                req_valid[i]       = (vmode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
                req_valid[i]       = 1'b0;
            end
        end
        tx_ready = (rmode == 1) ? 1'b1 : (rmode == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
    endtask

    task automatic release_owner();
        m_last = m_own;
        m_own  = -1;
    endtask

    task automatic step();
        bit         ev;
        logic [7:0] ed;
        logic [N-1:0] er;
        drive();
        @(negedge clk);
        ev = 0; ed = 8'h00; er = '0;
        if (!reset && m_own >= 0) begin
            if (m_tag) begin
                ev = 1; ed = TB + 8'(m_g);
            end else begin
                ev = req_valid[m_g]; ed = req_data[m_g*8 +: 8];
                if (tx_ready) er[m_g] = 1'b1;
            end
        end
        if (live) begin
            chk("tx_valid", tx_valid, ev);
            if (ev) chk("tx_data", tx_data, ed);
            chk("req_ready", req_ready, er);
            chk("busy", busy, m_own >= 0);
            chk("grant_id", grant_id, m_g);
        end
        if (tx_valid === 1'b1 && tx_ready) lg.push_back(tx_data);
        for (int i = 0; i < N; i++)
            if (er[i] && req_valid[i]) void'(rq[i].pop_front());
        // model update per the arbitration rules
        if (reset) begin
            m_own = -1; m_tag = 0; m_g = 0; m_last = N - 1; m_b = 0; m_i = 0;
        end else if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (m_own < 0 && req_valid[c]) begin
                    m_own = c; m_g = c; m_b = 0; m_i = 0; m_tag = (TE != 0);
                end
            end
        end else if (m_tag) begin
            if (tx_ready) m_tag = 0;
        end else if (req_valid[m_g] && tx_ready) begin
            m_b = (m_b < MB) ? m_b + 1 : m_b;
            m_i = 0;
            if (req_last[m_g] || (MB != 0 && m_b == MB)) release_owner();
        end else if (!req_valid[m_g]) begin
            m_i = (m_i < IT) ? m_i + 1 : m_i;
            if (IT != 0 && m_i == IT) release_owner();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic chk_stream(string tag, logic [7:0] exp[$]);
        chk({tag, "_len"}, lg.size(), exp.size());
        for (int k = 0; k < exp.size() && k < lg.size(); k++)
            chk(tag, lg[k], exp[k]);
        lg.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rq[i].delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        lg.delete();
    endtask

    initial begin
        reset = 1'b1;
        drive();
        step();
        live = 1;
        step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        lg.delete();

        // Single requester 1, three bytes
        rq[1].push_back(9'h041); rq[1].push_back(9'h042); rq[1].push_back(9'h143);
        run(8);
        chk_stream("p1_stream", '{8'h81, 8'h41, 8'h42, 8'h43});
        chk("p1_grant_id", grant_id, 1);

        // Requesters 0 and 2 together after reset: no interleaving
        do_reset();
        rq[0].push_back(9'h0A0); rq[0].push_back(9'h1A1);
        rq[2].push_back(9'h0C0); rq[2].push_back(9'h1C1);
        run(12);
        chk_stream("p2_stream", '{8'h80, 8'hA0, 8'hA1, 8'h82, 8'hC0, 8'hC1});

        // Burst limit 4 on a 10-byte unterminated stream, then idle timeout
        for (int j = 0; j < 10; j++) rq[3].push_back(9'(8'h10 + j));
        run(40);
        chk_stream("p3_stream", '{8'h83, 8'h10, 8'h11, 8'h12, 8'h13,
                                  8'h83, 8'h14, 8'h15, 8'h16, 8'h17,
                                  8'h83, 8'h18, 8'h19});

        // Idle timeout on requester 1 hands over to requester 0
        rq[1].push_back(9'h055);
        run(3);
        rq[0].push_back(9'h060); rq[0].push_back(9'h161);
        run(20);
        chk_stream("p4_stream", '{8'h81, 8'h55, 8'h80, 8'h60, 8'h61});

        // Tag stalled by tx_ready low for 50 cycles
        rmode = 0;
        rq[2].push_back(9'h177);
        run(52);
        chk("p5_tag_hold", tx_data, 8'h82);
        chk("p5_rq_kept", rq[2].size(), 1);
        rmode = 1;
        run(5);
        chk_stream("p5_stream", '{8'h82, 8'h77});

        // Reset in the middle of a message
        for (int j = 0; j < 8; j++) rq[1].push_back({(j == 7), 8'(8'h30 + j)});
        run(5);
        do_reset();
        chk("p6_busy", busy, 0);
        chk("p6_tx_valid", tx_valid, 0);
        chk("p6_req_ready", req_ready, 0);
        rq[3].push_back(9'h190); rq[0].push_back(9'h191);
        run(10);
        chk_stream("p6_stream", '{8'h80, 8'h91, 8'h83, 8'h90});

        // Random traffic
        vmode = 0; rmode = 2;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r = $urandom_range(0, N - 1);
                if (rq[r].size() < 4) begin
                    int len = $urandom_range(1, 6);
                    bit term = ($urandom_range(0, 4) != 0);
                    for (int j = 0; j < len; j++)
                        rq[r].push_back({(term && j == len - 1), 8'($urandom)});
                end
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end
        lg.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Arbitration is round-robin at message granularity, so bytes from different requesters never interleave inside a message.
- Optionally emits a one-byte channel tag before each granted message, so the host can demultiplex the serial stream.
- Sits between on-chip byte producers (console, debug, status) and the transmitter's data_in/data_in_valid/data_in_ready port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 64, maximum data bytes per grant before forced release; 0 means unlimited.
- IDLE_TIMEOUT, 1024, clock cycles the granted requester may hold req_valid low mid-message before forced release; 0 disables the timeout.
- TAG_EN, 1, 1 sends a tag byte before each message's data.
- TAG_BASE, 8'h80, tag byte value is TAG_BASE + grant index (8-bit wrap).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- req_data, input, NUM_REQ*8, byte from requester i on bits [8i+7:8i].
- req_valid, input, NUM_REQ, requester i has a byte.
- req_last, input, NUM_REQ, the byte is the last of a message; qualified by req_valid.
- req_ready, output, NUM_REQ, byte accepted from requester i this cycle.
- tx_data, output, 8, byte to the transmitter.
- tx_valid, output, 1, tx_data is valid.
- tx_ready, input, 1, transmitter accepts a byte (its data_in_ready).
- grant_id, output, $clog2(NUM_REQ), index of the current or most recent grant.
- busy, output, 1, a grant is held (state != IDLE).

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values: state IDLE; tx_valid=0; req_ready=0; busy=0; grant_id=0.
  - last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
  - Burst and timeout counters are 0.
- A byte transfers on any cycle where tx_valid && tx_ready.
- tx_valid and tx_data never depend combinationally on tx_ready.
- req_ready[g] = (state==DATA) && tx_ready; the bit is combinational. All other req_ready bits are 0.
- States: IDLE, TAG, DATA.
- IDLE:
  - Outputs are idle.
  - If any req_valid is set, pick the first set bit scanning from last_grant+1 upward with wrap.
  - Register the winner into grant, clear the counters, and go to TAG if TAG_EN, else DATA.
  - Arbitration costs exactly one cycle; no byte transfers in IDLE.
- TAG:
  - tx_valid=1 and tx_data=TAG_BASE+grant, held stable until accepted.
  - On transfer, go to DATA.
  - Requester valid changes in this state are ignored.
- DATA:
  - tx_valid=req_valid[grant] and tx_data=req_data[grant]; both pass through combinationally.
  - On a transfer, burst_cnt increments and the idle counter clears.
  - Release (go to IDLE, last_grant<=grant) when the transferred byte has req_last set, or when burst_cnt reaches MAX_BURST with MAX_BURST≠0.
  - While req_valid[grant]=0, the idle counter increments. When it reaches IDLE_TIMEOUT (IDLE_TIMEOUT≠0), release without a transfer.
  - Valid bits on non-granted requesters have no effect.
- Released requester: it ranks lowest in the next arbitration, even if it is still valid.
- Fairness: a single active requester re-wins every arbitration. With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- After a forced release (burst limit or timeout), that requester's next grant emits a fresh tag and continues its message.
- Counter widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST.
  - The idle counter is $clog2(IDLE_TIMEOUT+1) bits.
  - Neither counter wraps.
- grant_id holds its value through IDLE until the next arbitration.
- Reset mid-message: return immediately to the reset state. The partial message is abandoned; no tag or byte is emitted in the reset cycle.
- Throughput: at most one byte per cycle; the downstream transmitter normally limits the rate to one byte per 10 baud periods.

Test Plan:
- Single requester 1 sends 3 bytes 41,42,43 (last on 43), TAG_EN=1, tx_ready always 1 -> tx stream 81,41,42,43. IDLE cycle occurs before 81. busy deasserts the cycle after 43. grant_id=1.
- Requesters 0 and 2 both valid with 2-byte messages -> order 80,r0b0,r0b1,82,r2b0,r2b1. No interleaving. req_ready[2]=0 throughout r0's message.
- MAX_BURST=4, requester 3 streams 10 bytes without last -> requester 3 is granted three times, bytes split 4,4,2, each chunk preceded by tag 83.
- IDLE_TIMEOUT=8, requester 1 sends 1 byte then drops valid while requester 0 is valid -> release after 8 idle cycles, then tag 80 and r0 data follow.
- tx_ready low for 50 cycles during TAG -> tx_data stays 8'h8g and tx_valid stays 1. The requester byte is not consumed until after the tag transfers.
- Assert reset in DATA mid-message -> next cycle tx_valid=0, req_ready=0, busy=0. The next arbitration starts from requester 0.
